// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
//
// Serial bit-pattern detector with a loadable pattern register, optional
// overlapping matches, a saturating match counter and a sticky overflow flag.
//
// Ports (packed into two 8-bit buses):
//   io_in[0]  clock, all state updates on its rising edge
//   io_in[1]  reset, synchronous, active-high
//   io_in[2]  din      serial data bit, or pattern bit while load=1
//   io_in[3]  load     shift din into the pattern register
//   io_in[4]  en       sample din into the history when load=0
//   io_in[5]  overlap  1 = overlapping matches, 0 = non-overlapping
//   io_in[6]  clr      synchronous clear of match counter and overflow flag
//   io_in[7]  unused
//   io_out[0]          match pulse (one cycle, registered)
//   io_out[COUNT_W:1]  saturating match count (upper bits up to [4] read 0)
//   io_out[5]          loading, registered copy of load
//   io_out[6]          armed, history holds PAT_LEN-1 valid samples
//   io_out[7]          ovf, sticky: match seen while count saturated
// -----------------------------------------------------------------------------
module seq_pattern_detector #(
    parameter int                 PAT_LEN     = 3,
    parameter logic [PAT_LEN-1:0] PAT_DEFAULT = 3'b101,
    parameter int                 COUNT_W     = 4
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    // Fill only needs to reach PAT_LEN-1 (at most 7).
    localparam int                 FILL_W    = (PAT_LEN > 4) ? 3 : ((PAT_LEN > 2) ? 2 : 1);
    localparam logic [FILL_W-1:0]  FILL_MAX  = FILL_W'(PAT_LEN - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    logic w_clk;
    logic w_rst;
    logic w_din;
    logic w_load;
    logic w_en;
    logic w_overlap;
    logic w_clr;
    logic w_unused;

    assign w_clk     = io_in[0];
    assign w_rst     = io_in[1];
    assign w_din     = io_in[2];
    assign w_load    = io_in[3];
    assign w_en      = io_in[4];
    assign w_overlap = io_in[5];
    assign w_clr     = io_in[6];
    assign w_unused  = io_in[7];

    logic [PAT_LEN-2:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [PAT_LEN-1:0] r_pat;
    logic [COUNT_W-1:0] r_count;
    logic               r_match;
    logic               r_ovf;
    logic               r_loading;
    logic               r_armed;

    logic [PAT_LEN-2:0] w_hist_nxt;
    logic [FILL_W-1:0]  w_fill_nxt;
    logic [PAT_LEN-1:0] w_pat_nxt;
    logic [COUNT_W-1:0] w_count_nxt;
    logic               w_match_nxt;
    logic               w_ovf_nxt;
    logic               w_armed_nxt;

    logic [PAT_LEN-1:0] w_win;
    logic               w_accept;
    logic               w_hit;

    // Window: oldest sample in the MSB, the bit being presented in the LSB.
    assign w_win    = {r_hist, w_din};
    assign w_accept = w_en & ~w_load;
    assign w_hit    = w_accept & (r_fill == FILL_MAX) & (w_win == r_pat);

    // Next-state logic for history, fill, pattern, match, count and overflow.
    always_comb begin
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        w_pat_nxt   = r_pat;
        w_match_nxt = 1'b0;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;

        if (w_load) begin
            // Pattern shifts in MSB-first; history is kept but must refill.
            w_pat_nxt  = {r_pat[PAT_LEN-2:0], w_din};
            w_fill_nxt = {FILL_W{1'b0}};
        end else if (w_en) begin
            w_hist_nxt = w_win[PAT_LEN-2:0];
            if (w_hit) begin
                w_match_nxt = 1'b1;
                // Non-overlapping: demand a full fresh pattern's worth of bits.
                w_fill_nxt  = w_overlap ? FILL_MAX : {FILL_W{1'b0}};
            end else if (r_fill != FILL_MAX) begin
                w_fill_nxt = r_fill + FILL_W'(1);
            end else begin
                w_fill_nxt = r_fill;
            end
        end else begin
            w_hist_nxt = r_hist;
            w_fill_nxt = r_fill;
        end

        // clr outranks a coincident match; the match pulse itself still fires.
        if (w_clr) begin
            w_count_nxt = {COUNT_W{1'b0}};
            w_ovf_nxt   = 1'b0;
        end else if (w_hit) begin
            if (r_count != COUNT_MAX) begin
                w_count_nxt = r_count + COUNT_W'(1);
            end else begin
                w_ovf_nxt = 1'b1;
            end
        end else begin
            w_count_nxt = r_count;
            w_ovf_nxt   = r_ovf;
        end

        // Armed is registered from the next fill so it lines up with r_fill.
        w_armed_nxt = (w_fill_nxt == FILL_MAX);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_hist    <= {(PAT_LEN-1){1'b0}};
            r_fill    <= {FILL_W{1'b0}};
            r_pat     <= PAT_DEFAULT;
            r_count   <= {COUNT_W{1'b0}};
            r_match   <= 1'b0;
            r_ovf     <= 1'b0;
            r_loading <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_hist    <= w_hist_nxt;
            r_fill    <= w_fill_nxt;
            r_pat     <= w_pat_nxt;
            r_count   <= w_count_nxt;
            r_match   <= w_match_nxt;
            r_ovf     <= w_ovf_nxt;
            r_loading <= w_load;
            r_armed   <= w_armed_nxt;
        end
    end

    assign io_out[0]   = r_match;
    assign io_out[4:1] = 4'(r_count);
    assign io_out[5]   = r_loading;
    assign io_out[6]   = r_armed;
    assign io_out[7]   = r_ovf;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_detector
//
// Directed self-checking bench for seq_pattern_detector with default
// parameters (PAT_LEN=3, PAT_DEFAULT=101, COUNT_W=4). Inputs change 1 ns
// after a rising edge and outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       load = 1'b0;
    logic       en = 1'b0;
    logic       ovl = 1'b0;
    logic       clr = 1'b0;
    logic       spare = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int checks = 0;
    int errors = 0;
    int nmatch = 0;

    assign io_in = {spare, clr, ovl, en, load, din, rst, clk};

    seq_pattern_detector dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic d, input logic l,
                        input logic e, input logic o, input logic c);
        rst  = r;
        din  = d;
        load = l;
        en   = e;
        ovl  = o;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_all_zero", io_out, 8'h00);

        // ---------------- overlapping stream 1,0,1,0,1 ----------------
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovl_b1_match", {7'd0, io_out[0]}, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovl_b2_armed", {6'd0, io_out[6], io_out[0]}, 8'b10);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovl_b3_match", {7'd0, io_out[0]}, 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovl_b4_match", {7'd0, io_out[0]}, 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovl_b5_match", {7'd0, io_out[0]}, 8'd1);
        chk("ovl_count", {4'd0, io_out[4:1]}, 8'd2);
        chk("ovl_ovf", {7'd0, io_out[7]}, 8'd0);
        // en=0 holds count, drops match
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hold_en0", {io_out[4:1], io_out[0]}, {4'd2, 1'b0});

        // ---------------- non-overlapping stream ----------------
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("novl_b3_match_armed", {6'd0, io_out[6], io_out[0]}, 8'b01);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("novl_b4_match", {7'd0, io_out[0]}, 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("novl_b5_match", {7'd0, io_out[0]}, 8'd0);
        chk("novl_count", {4'd0, io_out[4:1]}, 8'd1);

        // ---------------- load pattern 110 (en held high) ----------------
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("load1", {io_out[5], io_out[0]}, 2'b10);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("load2", {io_out[5], io_out[0]}, 2'b10);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("load3", {io_out[5], io_out[0]}, 2'b10);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ld_s1_loading_off", {io_out[5], io_out[0]}, 2'b00);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ld_s3_no_match", {7'd0, io_out[0]}, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ld_s4_match", {io_out[4:1], io_out[0]}, {4'd1, 1'b1});

        // ---------------- saturation with pattern 111 ----------------
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            if (io_out[0] === 1'b1) nmatch++;
            chk($sformatf("sat_match_%0d", i), {7'd0, io_out[0]}, (i >= 3) ? 8'd1 : 8'd0);
            if (i == 17) chk("sat_at15_no_ovf", {io_out[7], io_out[4:1]}, {1'b0, 4'd15});
        end
        chk("sat_pulses", 8'(nmatch), 8'd18);
        chk("sat_count_ovf", {io_out[7], io_out[4:1]}, {1'b1, 4'd15});
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sat_clr", {io_out[7], io_out[4:1]}, 5'd0);

        // ---------------- reset mid-stream / mid-load ----------------
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_zero", io_out, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_mid_no_match", {io_out[4:1], io_out[0]}, 5'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_mid_pat101", {io_out[4:1], io_out[0]}, {4'd1, 1'b1});

        // ---------------- clr coincident with a match ----------------
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("clr_pre_count", {io_out[4:1], io_out[0]}, {4'd1, 1'b1});
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_collision", {io_out[7], io_out[4:1], io_out[0]}, {1'b0, 4'd0, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
